// File: rtl/addsub_arbiter.sv
// Two-requester front end for a shared pipelined add/subtract unit; responses return LATENCY+1 cycles after accept.
// Optional build macro ADDSUB_ARB_FIXED_PRIO_EN: requester 0 always wins ties and there is no round-robin state.
module addsub_arbiter #(
    parameter int LATENCY = 5
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [1:0]  req0_op,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [1:0]  req1_op,

    output logic        rsp0_valid,
    output logic [31:0] rsp0_sum,
    output logic        rsp0_cout,

    output logic        rsp1_valid,
    output logic [31:0] rsp1_sum,
    output logic        rsp1_cout,

    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_cin,
    output logic        add_neg_b,
    input  logic [31:0] add_sum,
    input  logic        add_cout,

    output logic        busy
);

    logic               w_acc0;
    logic               w_acc1;
    logic               w_acc;
    logic [31:0]        w_sel_a;
    logic [31:0]        w_sel_b;
    logic [1:0]         w_sel_op;
    logic               w_sel_cin;
    logic               w_sel_neg_b;
    logic               w_cap_vld;
    logic               w_cap_id;

    logic [31:0]        r_add_a;
    logic [31:0]        r_add_b;
    logic               r_add_cin;
    logic               r_add_neg_b;
    logic               r_iss_vld;
    logic               r_iss_id;
    logic [LATENCY-1:0] r_pipe_vld;
    logic [LATENCY-1:0] r_pipe_id;
    logic               r_rsp0_vld;
    logic [31:0]        r_rsp0_sum;
    logic               r_rsp0_cout;
    logic               r_rsp1_vld;
    logic [31:0]        r_rsp1_sum;
    logic               r_rsp1_cout;

`ifdef ADDSUB_ARB_FIXED_PRIO_EN
    assign req0_ready = req0_valid;
    assign req1_ready = req1_valid & ~req0_valid;
`else
    // r_last_gnt names the requester granted most recently; it loses the next tie.
    logic r_last_gnt;

    assign req0_ready = req0_valid & (~req1_valid | r_last_gnt);
    assign req1_ready = req1_valid & (~req0_valid | ~r_last_gnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_gnt <= 1'b1;
        end else if (w_acc) begin
            r_last_gnt <= w_acc1;
        end
    end
`endif

    assign w_acc0   = req0_valid & req0_ready;
    assign w_acc1   = req1_valid & req1_ready;
    assign w_acc    = w_acc0 | w_acc1;
    assign w_sel_a  = w_acc1 ? req1_a  : req0_a;
    assign w_sel_b  = w_acc1 ? req1_b  : req0_b;
    assign w_sel_op = w_acc1 ? req1_op : req0_op;

    // Subtraction is a + ~b + cin; borrow-in is expressed by dropping the +1.
    always_comb begin
        w_sel_cin   = 1'b0;
        w_sel_neg_b = 1'b0;
        case (w_sel_op)
            2'b00: begin w_sel_cin = 1'b0; w_sel_neg_b = 1'b0; end
            2'b01: begin w_sel_cin = 1'b1; w_sel_neg_b = 1'b0; end
            2'b10: begin w_sel_cin = 1'b1; w_sel_neg_b = 1'b1; end
            2'b11: begin w_sel_cin = 1'b0; w_sel_neg_b = 1'b1; end
            default: begin w_sel_cin = 1'b0; w_sel_neg_b = 1'b0; end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_add_a     <= '0;
            r_add_b     <= '0;
            r_add_cin   <= 1'b0;
            r_add_neg_b <= 1'b0;
        end else if (w_acc) begin
            r_add_a     <= w_sel_a;
            r_add_b     <= w_sel_b;
            r_add_cin   <= w_sel_cin;
            r_add_neg_b <= w_sel_neg_b;
        end
    end

    // Issue stage travels with the add_* registers; the LATENCY stages track the adder's own pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iss_vld  <= 1'b0;
            r_iss_id   <= 1'b0;
            r_pipe_vld <= '0;
            r_pipe_id  <= '0;
        end else begin
            r_iss_vld     <= w_acc;
            r_iss_id      <= w_acc1;
            r_pipe_vld[0] <= r_iss_vld;
            r_pipe_id[0]  <= r_iss_id;
            for (int i = 1; i < LATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_id[i]  <= r_pipe_id[i-1];
            end
        end
    end

    assign w_cap_vld = r_pipe_vld[LATENCY-1];
    assign w_cap_id  = r_pipe_id[LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp0_vld  <= 1'b0;
            r_rsp0_sum  <= '0;
            r_rsp0_cout <= 1'b0;
            r_rsp1_vld  <= 1'b0;
            r_rsp1_sum  <= '0;
            r_rsp1_cout <= 1'b0;
        end else begin
            r_rsp0_vld <= w_cap_vld & ~w_cap_id;
            r_rsp1_vld <= w_cap_vld &  w_cap_id;
            if (w_cap_vld && !w_cap_id) begin
                r_rsp0_sum  <= add_sum;
                r_rsp0_cout <= add_cout;
            end
            if (w_cap_vld && w_cap_id) begin
                r_rsp1_sum  <= add_sum;
                r_rsp1_cout <= add_cout;
            end
        end
    end

    assign add_a      = r_add_a;
    assign add_b      = r_add_b;
    assign add_cin    = r_add_cin;
    assign add_neg_b  = r_add_neg_b;
    assign rsp0_valid = r_rsp0_vld;
    assign rsp0_sum   = r_rsp0_sum;
    assign rsp0_cout  = r_rsp0_cout;
    assign rsp1_valid = r_rsp1_vld;
    assign rsp1_sum   = r_rsp1_sum;
    assign rsp1_cout  = r_rsp1_cout;
    assign busy       = r_iss_vld | (|r_pipe_vld) | r_rsp0_vld | r_rsp1_vld;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter with a LATENCY-deep adder model on the add_* interface.
module tb_addsub_arbiter;

    localparam int LAT = 5;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_sum, rsp1_sum;
    logic        rsp0_cout, rsp1_cout;
    logic [31:0] add_a, add_b;
    logic        add_cin, add_neg_b;
    logic [31:0] add_sum;
    logic        add_cout;
    logic        busy;

    int total = 0;
    int bad   = 0;

    addsub_arbiter #(.LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_sum(rsp0_sum), .rsp0_cout(rsp0_cout),
        .rsp1_valid(rsp1_valid), .rsp1_sum(rsp1_sum), .rsp1_cout(rsp1_cout),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_neg_b(add_neg_b),
        .add_sum(add_sum), .add_cout(add_cout),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External adder: LAT register stages fed by the registered add_* outputs.
    logic [32:0] m_pipe [LAT];
    always @(posedge clk) begin
        m_pipe[0] <= {1'b0, add_a} + {1'b0, (add_neg_b ? ~add_b : add_b)} + {32'd0, add_cin};
        for (int i = 1; i < LAT; i++) m_pipe[i] <= m_pipe[i-1];
    end
    assign add_sum  = m_pipe[LAT-1][31:0];
    assign add_cout = m_pipe[LAT-1][32];

    task automatic clear_inputs();
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req0_op = 0;
        req1_a = 0; req1_b = 0; req1_op = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        #3;
        total++;
        if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
            bad++; $display("FAIL reset_flags busy=%b rsp0_valid=%b rsp1_valid=%b required 0 0 0", busy, rsp0_valid, rsp1_valid);
        end
        total++;
        if (add_a !== 32'd0 || add_b !== 32'd0 || add_cin !== 1'b0 || add_neg_b !== 1'b0) begin
            bad++; $display("FAIL reset_add add_a=%h add_b=%h cin=%b neg_b=%b required all 0", add_a, add_b, add_cin, add_neg_b);
        end
        total++;
        if (rsp0_sum !== 32'd0 || rsp0_cout !== 1'b0 || rsp1_sum !== 32'd0 || rsp1_cout !== 1'b0) begin
            bad++; $display("FAIL reset_rsp rsp0=%h/%b rsp1=%h/%b required 0/0 0/0", rsp0_sum, rsp0_cout, rsp1_sum, rsp1_cout);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        total++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            bad++; $display("FAIL idle_ready ready0=%b ready1=%b required 0 0", req0_ready, req1_ready);
        end
    endtask

    task automatic test_single_add();
        do_reset();
        req0_a = 5; req0_b = 3; req0_op = 2'b00; req0_valid = 1;
        #1;
        total++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            bad++; $display("FAIL single_grant ready0=%b ready1=%b required 1 0", req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        req0_valid = 0;
        total++;
        if (add_a !== 32'd5 || add_b !== 32'd3 || add_cin !== 1'b0 || add_neg_b !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL single_issue add_a=%0d add_b=%0d cin=%b neg_b=%b busy=%b required 5 3 0 0 1",
                            add_a, add_b, add_cin, add_neg_b, busy);
        end
        for (int e = 1; e <= 8; e++) begin
            logic exp_busy, exp_v0;
            @(posedge clk); #1;
            exp_busy = (e <= 6);
            exp_v0   = (e == 6);
            total++;
            if (rsp1_valid !== 1'b0) begin
                bad++; $display("FAIL single_rsp1 edge=%0d rsp1_valid=%b required 0", e, rsp1_valid);
            end
            total++;
            if (busy !== exp_busy) begin
                bad++; $display("FAIL single_busy edge=%0d busy=%b required %b", e, busy, exp_busy);
            end
            total++;
            if (rsp0_valid !== exp_v0) begin
                bad++; $display("FAIL single_rsp0_valid edge=%0d got=%b required %b", e, rsp0_valid, exp_v0);
            end
            if (e == 6) begin
                total++;
                if (rsp0_sum !== 32'd8 || rsp0_cout !== 1'b0) begin
                    bad++; $display("FAIL single_result sum=%0d cout=%b required 8 0", rsp0_sum, rsp0_cout);
                end
            end
            if (e == 8) begin
                total++;
                if (rsp0_sum !== 32'd8 || add_a !== 32'd5 || add_b !== 32'd3 || add_cin !== 1'b0 || add_neg_b !== 1'b0) begin
                    bad++; $display("FAIL single_hold rsp0_sum=%0d add_a=%0d add_b=%0d cin=%b neg_b=%b required 8 5 3 0 0",
                                    rsp0_sum, add_a, add_b, add_cin, add_neg_b);
                end
            end
        end
    endtask

    task automatic test_dual();
        do_reset();
        req0_a = 10; req0_b = 4; req0_op = 2'b10;
        req1_a = 1;  req1_b = 1; req1_op = 2'b01;
        for (int e = 0; e <= 11; e++) begin
            logic g0, g1, v0, v1;
`ifdef ADDSUB_ARB_FIXED_PRIO_EN
            req0_valid = (e < 4);
            req1_valid = (e < 5);
            g0 = (e < 4);
            g1 = (e == 4);
            v0 = (e >= 6 && e <= 9);
            v1 = (e == 10);
`else
            req0_valid = (e < 4);
            req1_valid = (e < 4);
            g0 = (e == 0 || e == 2);
            g1 = (e == 1 || e == 3);
            v0 = (e == 6 || e == 8);
            v1 = (e == 7 || e == 9);
`endif
            #1;
            if (e < 5) begin
                total++;
                if (req0_ready !== g0 || req1_ready !== g1) begin
                    bad++; $display("FAIL dual_grant cycle=%0d ready0=%b ready1=%b required %b %b", e, req0_ready, req1_ready, g0, g1);
                end
            end
            @(posedge clk); #1;
            if (e == 0) begin
                total++;
                if (add_a !== 32'd10 || add_b !== 32'd4 || add_cin !== 1'b1 || add_neg_b !== 1'b1) begin
                    bad++; $display("FAIL dual_sub_ctrl add_a=%0d add_b=%0d cin=%b neg_b=%b required 10 4 1 1", add_a, add_b, add_cin, add_neg_b);
                end
            end
            total++;
            if (rsp0_valid !== v0 || rsp1_valid !== v1) begin
                bad++; $display("FAIL dual_rsp_valid edge=%0d rsp0=%b rsp1=%b required %b %b", e, rsp0_valid, rsp1_valid, v0, v1);
            end
            if (v0) begin
                total++;
                if (rsp0_sum !== 32'd6 || rsp0_cout !== 1'b1) begin
                    bad++; $display("FAIL dual_rsp0_data edge=%0d sum=%0d cout=%b required 6 1", e, rsp0_sum, rsp0_cout);
                end
            end
            if (v1) begin
                total++;
                if (rsp1_sum !== 32'd3 || rsp1_cout !== 1'b0) begin
                    bad++; $display("FAIL dual_rsp1_data edge=%0d sum=%0d cout=%b required 3 0", e, rsp1_sum, rsp1_cout);
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_sbb();
        req1_a = 0; req1_b = 0; req1_op = 2'b11;
        for (int e = 0; e <= 7; e++) begin
            req1_valid = (e == 0);
            @(posedge clk); #1;
            if (e == 0) begin
                total++;
                if (add_neg_b !== 1'b1 || add_cin !== 1'b0) begin
                    bad++; $display("FAIL sbb_ctrl neg_b=%b cin=%b required 1 0", add_neg_b, add_cin);
                end
            end
            total++;
            if (rsp1_valid !== (e == 6) || rsp0_valid !== 1'b0) begin
                bad++; $display("FAIL sbb_valid edge=%0d rsp1=%b rsp0=%b required %b 0", e, rsp1_valid, rsp0_valid, (e == 6));
            end
            if (e == 6) begin
                total++;
                if (rsp1_sum !== 32'hFFFF_FFFF || rsp1_cout !== 1'b0) begin
                    bad++; $display("FAIL sbb_result sum=%h cout=%b required ffffffff 0", rsp1_sum, rsp1_cout);
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset_flush();
        for (int e = 0; e <= 2; e++) begin
            req0_a = e + 1; req0_b = 1; req0_op = 2'b00; req0_valid = 1;
            @(posedge clk); #1;
        end
        clear_inputs();
        rst_n = 0;
        #1;
        total++;
        if (busy !== 1'b0 || rsp0_valid !== 1'b0 || add_a !== 32'd0 || add_b !== 32'd0 || rsp0_sum !== 32'd0) begin
            bad++; $display("FAIL flush_async busy=%b rsp0_valid=%b add_a=%0d add_b=%0d rsp0_sum=%0d required 0 0 0 0 0",
                            busy, rsp0_valid, add_a, add_b, rsp0_sum);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            total++;
            if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
                bad++; $display("FAIL flush_dropped cycle=%0d busy=%b rsp0=%b rsp1=%b required 0 0 0", k, busy, rsp0_valid, rsp1_valid);
            end
        end
        req0_a = 7; req0_b = 9; req0_op = 2'b00;
        for (int e = 0; e <= 7; e++) begin
            req0_valid = (e == 0);
            @(posedge clk); #1;
            total++;
            if (rsp0_valid !== (e == 6)) begin
                bad++; $display("FAIL flush_new_valid edge=%0d rsp0=%b required %b", e, rsp0_valid, (e == 6));
            end
            if (e == 6) begin
                total++;
                if (rsp0_sum !== 32'd16 || rsp0_cout !== 1'b0) begin
                    bad++; $display("FAIL flush_new_result sum=%0d cout=%b required 16 0", rsp0_sum, rsp0_cout);
                end
            end
        end
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_add();
        test_dual();
        test_sbb();
        test_reset_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
